vx_sfu_pe_router: RTL

// - Parametrised request/response router between the SFU dispatch stage and PE_COUNT processing elements (wctl, csr, future PEs).
// - Steers each request to the PE named by req_pe_sel and caps outstanding work per PE with an in-flight credit counter.
// - Merges PE responses through a round-robin arbiter into one registered output stream toward the gather stage.

---
 rtl/vx_sfu_pe_router.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vx_sfu_pe_router.sv
`default_nettype none
// ============================================================================
// Module      : vx_sfu_pe_router
// Description : Request/response router between the SFU dispatch stage and
//               PE_COUNT processing elements. Requests are steered
//               combinationally to the selected PE. A per-PE credit counter
//               limits the work outstanding on each PE. PE responses are
//               merged round-robin into one registered output stream.
//               Optional feature macro: SFU_PE_ROUTER_PERF_EN adds per-PE
//               32-bit request-stall counters on perf_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_sfu_pe_router #(
    parameter int PE_COUNT     = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int RSP_WIDTH    = 64,
    parameter int MAX_INFLIGHT = 4,
    localparam int PE_SEL_BITS = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
    localparam int CNT_BITS    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [PE_SEL_BITS-1:0]        req_pe_sel,
    input  logic [DATA_WIDTH-1:0]         req_data,
    output logic [PE_COUNT-1:0]           pe_req_valid,
    input  logic [PE_COUNT-1:0]           pe_req_ready,
    output logic [DATA_WIDTH-1:0]         pe_req_data,
    input  logic [PE_COUNT-1:0]           pe_rsp_valid,
    output logic [PE_COUNT-1:0]           pe_rsp_ready,
    input  logic [PE_COUNT*RSP_WIDTH-1:0] pe_rsp_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [RSP_WIDTH-1:0]          rsp_data,
    output logic [PE_SEL_BITS-1:0]        rsp_pe_idx,
    output logic                          busy
`ifdef SFU_PE_ROUTER_PERF_EN
    ,
    output logic [PE_COUNT*32-1:0]        perf_stall_cnt
`endif
);

    localparam logic [CNT_BITS-1:0]    c_cnt_max  = CNT_BITS'(MAX_INFLIGHT);
    localparam logic [CNT_BITS-1:0]    c_cnt_one  = CNT_BITS'(1);
    localparam logic [PE_SEL_BITS-1:0] c_last_idx = PE_SEL_BITS'(PE_COUNT - 1);
    localparam logic [PE_SEL_BITS-1:0] c_idx_one  = PE_SEL_BITS'(1);

    logic [PE_COUNT-1:0]    w_sel_hot;
    logic [PE_COUNT-1:0]    w_full;
    logic [PE_COUNT-1:0]    w_req_hs;
    logic [PE_COUNT-1:0]    w_rsp_hs;
    logic [PE_COUNT-1:0]    w_cnt_nz;

    logic                   w_load;
    logic                   w_any;
    logic [PE_SEL_BITS-1:0] w_grant_idx;
    logic [RSP_WIDTH-1:0]   w_grant_data;
    int                     w_best_dist;
    int                     w_dist;

    logic [PE_SEL_BITS-1:0] r_ptr;
    logic                   r_rsp_valid;
    logic [RSP_WIDTH-1:0]   r_rsp_data;
    logic [PE_SEL_BITS-1:0] r_rsp_pe_idx;

    // An out-of-range select matches no bit of w_sel_hot, so the request
    // simply stalls with no PE valid raised.
    assign req_ready   = |(w_sel_hot & pe_req_ready & ~w_full);
    assign pe_req_data = req_data;

    // The output register can take a new response when empty or draining.
    assign w_load = ~r_rsp_valid | rsp_ready;

    generate
        for (genvar i = 0; i < PE_COUNT; i++) begin : g_pe
            logic [CNT_BITS-1:0] r_cnt;

            assign w_sel_hot[i]    = (req_pe_sel == PE_SEL_BITS'(i));
            assign w_full[i]       = (r_cnt == c_cnt_max);
            assign pe_req_valid[i] = req_valid & w_sel_hot[i] & ~w_full[i];
            assign w_req_hs[i]     = pe_req_valid[i] & pe_req_ready[i];
            assign pe_rsp_ready[i] = w_load & w_any & (w_grant_idx == PE_SEL_BITS'(i));
            assign w_rsp_hs[i]     = pe_rsp_valid[i] & pe_rsp_ready[i];
            assign w_cnt_nz[i]     = |r_cnt;

            // In-flight credit count: +1 on issue, -1 on return, both cancel.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_req_hs[i] && !w_rsp_hs[i] && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end else if (w_rsp_hs[i] && !w_req_hs[i] && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
            end

`ifdef SFU_PE_ROUTER_PERF_EN
            logic [31:0] r_stall_cnt;

            // Count cycles a request aimed at this PE is held off; wraps freely.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stall_cnt <= '0;
                end else if (req_valid && w_sel_hot[i] && !req_ready) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end

            assign perf_stall_cnt[i*32 +: 32] = r_stall_cnt;
`endif

`ifndef SYNTHESIS
            a_no_rsp_underflow : assert property (
                @(posedge clk) disable iff (reset) w_rsp_hs[i] |-> (r_cnt != '0));
`endif
        end
    endgenerate

    // Round-robin pick: the valid PE closest to r_ptr (wrapping) wins.
    always_comb begin
        w_any        = 1'b0;
        w_grant_idx  = '0;
        w_best_dist  = PE_COUNT;
        w_dist       = 0;
        w_grant_data = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            w_dist = i - int'(r_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + PE_COUNT;
            end
            if (pe_rsp_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_grant_idx = PE_SEL_BITS'(i);
                w_any       = 1'b1;
            end
        end
        for (int i = 0; i < PE_COUNT; i++) begin
            if (w_grant_idx == PE_SEL_BITS'(i)) begin
                w_grant_data = pe_rsp_data[i*RSP_WIDTH +: RSP_WIDTH];
            end
        end
    end

    // Single-entry output register and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_pe_idx <= '0;
            r_ptr        <= '0;
        end else if (w_load && w_any) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= w_grant_data;
            r_rsp_pe_idx <= w_grant_idx;
            r_ptr        <= (w_grant_idx == c_last_idx) ? '0 : (w_grant_idx + c_idx_one);
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_pe_idx = r_rsp_pe_idx;
    assign busy       = (|w_cnt_nz) | r_rsp_valid;

`ifndef SYNTHESIS
    a_sel_in_range : assert property (
        @(posedge clk) disable iff (reset) req_valid |-> (int'(req_pe_sel) < PE_COUNT));
`endif

endmodule
`default_nettype wire
